me_job_sched: RTL
=================

Name: me_job_sched

Overview:
- Scheduler placed in front of the modular-exponentiation wrapper.
- Shares one ME core between NUM_REQ requesters using round-robin arbitration.
- Sequences each job's enable pulses: pre-compute then exponentiation, or a single Montgomery multiply.
- Detects completion from the core's toggling done line and returns a tagged response through a valid/ready handshake.

Parameters:
- NUM_REQ, 4: number of requesters (2..15).
- IDX_W, 2: width of requester index, equal to clog2(NUM_REQ).
- TO_W, 24: width of the watchdog counter (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester job request; held until the matching req_ready.
- req_op  in  2*NUM_REQ  per-requester op, 2 bits per requester: 0=pre+me, 1=one_mm, 2=me only, 3=reserved.
- req_ready  out  NUM_REQ  one-cycle accept strobe for the granted requester.
- sel_idx  out  IDX_W  index of the current owner; drives the external operand mux.
- core_num  out  4  tag presented on the core's num input; zero-extended sel_idx.
- core_en_pre_me  out  1  level to core, pulsed high for one cycle.
- core_en_me  out  1  level to core, pulsed high for one cycle.
- core_en_one_mm  out  1  level to core, pulsed high for one cycle.
- core_done_tgl  in  1  core done line; toggles once per finished operation.
- core_num_out  in  4  tag returned by the core.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_idx  out  IDX_W  requester index the response belongs to.
- rsp_err  out  2  bit0 = timeout, bit1 = tag mismatch.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at posedge clk), all registers cleared:
  - req_ready=0, core_en_*=0, rsp_valid=0, rsp_idx=0, rsp_err=0, sel_idx=0, busy=0.
  - RR pointer=0, done_q sampled from core_done_tgl, state=IDLE.
- Reset mid-job abandons the job. The core is not reset by this block.
- done_q re-samples core_done_tgl during reset, so no spurious done event follows reset.
- done_evt = core_done_tgl XOR done_q, where done_q is core_done_tgl registered every cycle.
- IDLE:
  - If any req_valid, pick the first asserted index scanning ptr, ptr+1, … modulo NUM_REQ.
  - Register the winner into sel_idx, go to GRANT.
- GRANT (1 cycle):
  - req_ready[sel_idx]=1.
  - Latch req_op[sel_idx].
  - ptr <= sel_idx+1, wrapping NUM_REQ-1 -> 0.
  - Next state by op: 0 -> PRE_GO, 1 -> MM_GO, 2 -> ME_GO, 3 -> RESP with rsp_err=2'b10.
- PRE_GO (1 cycle): core_en_pre_me=1 -> PRE_WAIT.
- PRE_WAIT: on done_evt -> ME_GO.
- ME_GO (1 cycle): core_en_me=1 -> ME_WAIT.
- ME_WAIT: on done_evt -> RESP.
- MM_GO (1 cycle): core_en_one_mm=1 -> MM_WAIT.
- MM_WAIT: on done_evt -> RESP.
- GO/WAIT gap:
  - Each enable is low in the cycle after its GO state, so every GO state yields exactly one rising edge.
  - Back-to-back jobs therefore always present a fresh edge to the core.
- done_evt outside a WAIT state is ignored.
- On the final done_evt, rsp_err[1] <= (core_num_out != core_num).
- RESP:
  - rsp_valid=1, rsp_idx=sel_idx, rsp_err held.
  - On rsp_ready, clear rsp_valid and rsp_err -> IDLE.
  - No new grant until the response is consumed (one outstanding job).
- Latency:
  - Request seen in IDLE at cycle T: req_ready at T+1, first enable at T+2.
  - rsp_valid asserts the cycle after the final done_evt.
- Fairness: the requester granted last has lowest priority next round; a requester with valid held waits at most NUM_REQ-1 jobs.
- req_valid dropped before grant is legal; it is simply not selected.

Optional Feature:
- Macro ME_JOB_SCHED_TIMEOUT_EN.
- When defined:
  - Input port to_limit [TO_W-1:0] is added.
  - A counter clears on entry to each WAIT state and increments every WAIT cycle.
  - When count reaches to_limit without done_evt, set rsp_err[0] and go to RESP.
  - to_limit=0 disables the watchdog.
- When undefined: no port, no counter, rsp_err[0] constant 0, WAIT states wait indefinitely.

Test Plan:
- Reset then req_valid=4'b0001, op=0 -> req_ready[0] one cycle; en_pre_me pulse at T+2; after core toggle, en_me pulse; after second toggle, rsp_valid with rsp_idx=0, rsp_err=0.
- req_valid=4'b1111, all op=1, rsp_ready tied 1 -> grant order 0,1,2,3,0; exactly one en_one_mm pulse per job; no pulse while RESP pending.
- op=2 on requester 2, core_num_out returned as 5 -> single en_me pulse; rsp_idx=2, rsp_err=2'b10.
- Stray core_done_tgl toggle while IDLE, then op=1 request -> no early completion; response only after a toggle in MM_WAIT.
- rst_n low for 1 cycle during ME_WAIT -> all outputs 0, state IDLE; a later done toggle produces no response.
- With ME_JOB_SCHED_TIMEOUT_EN and to_limit=100, core silent -> rsp_valid 100 cycles after WAIT entry with rsp_err=2'b01.

Source files
------------

// File: rtl/me_job_sched.sv
// Round-robin job scheduler sharing one modular-exponentiation core.
// Optional watchdog enabled by defining ME_JOB_SCHED_TIMEOUT_EN.
module me_job_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TO_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [IDX_W-1:0]     sel_idx,
  output logic [3:0]           core_num,
  output logic                 core_en_pre_me,
  output logic                 core_en_me,
  output logic                 core_en_one_mm,
  input  logic                 core_done_tgl,
  input  logic [3:0]           core_num_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDX_W-1:0]     rsp_idx,
  output logic [1:0]           rsp_err,
`ifdef ME_JOB_SCHED_TIMEOUT_EN
  input  logic [TO_W-1:0]      to_limit,
`endif
  output logic                 busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_PRE_GO,
    S_PRE_WAIT,
    S_ME_GO,
    S_ME_WAIT,
    S_MM_GO,
    S_MM_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       err_q, err_d;
  logic             done_q;
  logic             done_evt;
  logic             tag_bad;
  logic             to_hit;
  logic             any_req;
  logic [IDX_W-1:0] win;
  logic [1:0]       op_cur;
  logic [IDX_W-1:0] ptr_nxt;

  if (IDX_W < 1 || TO_W < 1) begin : g_bad_cfg
  end

  // Done line toggles per operation; resampled in reset too.
  always_ff @(posedge clk) begin
    done_q <= core_done_tgl;
  end

  assign done_evt = core_done_tgl ^ done_q;
  assign core_num = 4'(sel_q);
  assign tag_bad  = (core_num_out != core_num);

  always_comb begin
    any_req = 1'b0;
    win     = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = int'(ptr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any_req && req_valid[c]) begin
        any_req = 1'b1;
        win     = c[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    op_cur = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel_q) op_cur = req_op[2*i +: 2];
    end
  end

  assign ptr_nxt = (sel_q == IDX_W'(NUM_REQ - 1)) ?
                   '0 : sel_q + 1'b1;

`ifdef ME_JOB_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q;
  logic            in_wait;
  logic            in_go;

  assign in_wait = (state_q == S_PRE_WAIT) ||
                   (state_q == S_ME_WAIT) ||
                   (state_q == S_MM_WAIT);
  assign in_go   = (state_q == S_PRE_GO) ||
                   (state_q == S_ME_GO) ||
                   (state_q == S_MM_GO);

  // GO always precedes WAIT, so clearing there covers each entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (in_go) begin
      cnt_q <= '0;
    end else if (in_wait) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign to_hit = in_wait && (to_limit != '0) &&
                  (cnt_q == to_limit - 1'b1);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sel_d   = win;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        ptr_d = ptr_nxt;
        unique case (op_cur)
          2'd0:    state_d = S_PRE_GO;
          2'd1:    state_d = S_MM_GO;
          2'd2:    state_d = S_ME_GO;
          default: begin
            err_d   = 2'b10;
            state_d = S_RESP;
          end
        endcase
      end
      S_PRE_GO: state_d = S_PRE_WAIT;
      S_PRE_WAIT: begin
        if (done_evt) begin
          state_d = S_ME_GO;
        end else if (to_hit) begin
          err_d[0] = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_ME_GO: state_d = S_ME_WAIT;
      S_MM_GO: state_d = S_MM_WAIT;
      S_ME_WAIT, S_MM_WAIT: begin
        if (done_evt) begin
          err_d[1] = tag_bad;
          state_d  = S_RESP;
        end else if (to_hit) begin
          err_d[0] = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          err_d   = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_GRANT) req_ready[sel_q] = 1'b1;
  end

  assign sel_idx        = sel_q;
  assign core_en_pre_me = (state_q == S_PRE_GO);
  assign core_en_me     = (state_q == S_ME_GO);
  assign core_en_one_mm = (state_q == S_MM_GO);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_idx        = rsp_valid ? sel_q : '0;
  assign rsp_err        = err_q;
  assign busy           = (state_q != S_IDLE);

endmodule
